alu_share_arbiter: RTL

- Shares one 4-bit ALU_N_bits datapath among 4 requesters using valid/ready handshakes and round-robin arbitration.
- Latches the granted operands, executes, and returns a registered result with the requester ID on a single response channel.
- Holds the last completed result for the downstream 7-segment display decoder.

---
 rtl/alu_share_arbiter_if.sv | 38 +++
 rtl/alu_share_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
// Bundles the request/response handshake and the display outputs of the
// shared-ALU arbiter.
//   req_valid/req_ready : per-requester valid and one-hot grant
//   req_a/req_b/req_op  : packed per-requester operands and opcodes
//   rsp_*               : single response channel (valid/ready, owner id, data)
//   disp_data/disp_en   : last completed result for the 7-segment decoder
//   busy                : arbiter is executing or holding a response
// Modports: master = requester/consumer side, slave = arbiter side.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [2*NREQ-1:0]     req_op;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_data;
    logic [WIDTH-1:0]      disp_data;
    logic                  disp_en;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, disp_data, disp_en, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, disp_data, disp_en, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one small ALU among NREQ requesters. In IDLE a round-robin search
// starting at ptr grants one valid requester; its operands are latched, the
// ALU runs for one EXEC cycle, and the result is presented on the response
// channel (RESP) until accepted. The last completed result is also held for
// a 7-segment display decoder.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_share_arbiter_if.slave (handshakes, operands, response, display, busy)
module alu_share_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0]     OP_ADD = 2'b00;
    localparam logic [1:0]     OP_SUB = 2'b01;
    localparam logic [1:0]     OP_AND = 2'b10;
    localparam logic [1:0]     OP_OR  = 2'b11;
    localparam logic [IDW-1:0] ID_ONE = IDW'(1);
    localparam logic [IDW-1:0] ID_MAX = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // ALU: results wrap modulo 2**WIDTH, carry and borrow are dropped.
    function automatic logic [WIDTH-1:0] alu_calc(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [1:0]       op
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    // Round-robin pick: first valid requester at ptr, ptr+1, ... (mod NREQ).
    function automatic logic [NREQ-1:0] rr_pick(
        input logic [NREQ-1:0] valid,
        input logic [IDW-1:0]  ptr
    );
        logic [NREQ-1:0] g;
        logic [IDW-1:0]  idx;
        logic            found;
        g     = {NREQ{1'b0}};
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!found && valid[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end else begin
                found = found;
            end
        end
        return g;
    endfunction

    state_t           state_r;
    state_t           next_state_s;
    logic [IDW-1:0]   ptr_r;
    logic [IDW-1:0]   ptr_next_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [1:0]       op_r;
    logic [IDW-1:0]   id_r;
    logic             rsp_valid_r;
    logic [IDW-1:0]   rsp_id_r;
    logic [WIDTH-1:0] rsp_data_r;
    logic [WIDTH-1:0] disp_data_r;
    logic             disp_en_r;
    logic [NREQ-1:0]  grant_s;
    logic             xfer_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;
    logic [1:0]       sel_op_s;
    logic [IDW-1:0]   sel_id_s;
    logic [WIDTH-1:0] alu_s;

    // The grant only ever targets a valid requester, so any grant is a transfer.
    assign xfer_s     = |grant_s;
    assign alu_s      = alu_calc(a_r, b_r, op_r);
    assign ptr_next_s = (id_r == ID_MAX) ? {IDW{1'b0}} : (id_r + ID_ONE);

    assign bus.req_ready = grant_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.disp_data = disp_data_r;
    assign bus.disp_en   = disp_en_r;
    assign bus.busy      = (state_r != IDLE);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next state and grant; the grant is gated while reset is asserted
    // so req_ready reads 0 during reset even with requests pending.
    always_comb begin
        next_state_s = state_r;
        grant_s      = {NREQ{1'b0}};
        case (state_r)
            IDLE: begin
                if (rst_n) begin
                    grant_s = rr_pick(bus.req_valid, ptr_r);
                end else begin
                    grant_s = {NREQ{1'b0}};
                end
                if (|grant_s) begin
                    next_state_s = EXEC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            EXEC: next_state_s = RESP;
            RESP: begin
                if (rsp_valid_r && bus.rsp_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Operand mux: select the granted requester's fields.
    always_comb begin
        sel_a_s  = {WIDTH{1'b0}};
        sel_b_s  = {WIDTH{1'b0}};
        sel_op_s = 2'b00;
        sel_id_s = {IDW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            if (grant_s[k]) begin
                sel_a_s  = bus.req_a[k*WIDTH +: WIDTH];
                sel_b_s  = bus.req_b[k*WIDTH +: WIDTH];
                sel_op_s = bus.req_op[2*k +: 2];
                sel_id_s = IDW'(k);
            end else begin
                sel_a_s  = sel_a_s;
            end
        end
    end

    // Datapath: operand latch, result/response registers, display hold, pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r       <= {IDW{1'b0}};
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            op_r        <= 2'b00;
            id_r        <= {IDW{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= {IDW{1'b0}};
            rsp_data_r  <= {WIDTH{1'b0}};
            disp_data_r <= {WIDTH{1'b0}};
            disp_en_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (xfer_s) begin
                        a_r  <= sel_a_s;
                        b_r  <= sel_b_s;
                        op_r <= sel_op_s;
                        id_r <= sel_id_s;
                    end
                end
                EXEC: begin
                    rsp_data_r  <= alu_s;
                    rsp_id_r    <= id_r;
                    rsp_valid_r <= 1'b1;
                    disp_data_r <= alu_s;
                    disp_en_r   <= 1'b1;
                end
                RESP: begin
                    // The granted requester drops to lowest priority next round.
                    if (rsp_valid_r && bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        ptr_r       <= ptr_next_s;
                    end
                end
                default: rsp_valid_r <= 1'b0;
            endcase
        end
    end
endmodule
